// File: rtl/psx_link_pkg.sv
// psx_link_pkg: constants and FSM state type for the DE2-115 -> VC707 return link.
// Shared with the VC707-side receiver, so the defaults here define the wire format:
//   CHAN_W : link channel width per beat
//   WORD_W : payload word width
//   BEATS  : beats per word, ceil(WORD_W / CHAN_W)
package psx_link_pkg;

  localparam int unsigned CHAN_W = 6;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned BEATS  = (WORD_W + CHAN_W - 1) / CHAN_W;

  typedef enum logic [2:0] {
    StIdle,
    StLow,
    StHigh,
    StAckHi,
    StAckLo
  } link_state_e;

endpackage

// File: rtl/de2115_return_tx_if.sv
// de2115_return_tx_if: the return-link wires between transmitter and receiver.
//   com_channel : current beat (tx -> rx)
//   com_clk     : beat strobe, rx samples com_channel on its rising edge (tx -> rx)
//   com_req     : high for the whole beat sequence of one word (tx -> rx)
//   com_ack     : word-taken acknowledge, asynchronous to the tx clock (rx -> tx)
// Modports: master = transmitter side, slave = receiver side.
interface de2115_return_tx_if #(
  parameter int unsigned CHAN_W = psx_link_pkg::CHAN_W
);

  logic [CHAN_W-1:0] com_channel;
  logic              com_clk;
  logic              com_req;
  logic              com_ack;

  modport master (
    output com_channel,
    output com_clk,
    output com_req,
    input  com_ack
  );

  modport slave (
    input  com_channel,
    input  com_clk,
    input  com_req,
    output com_ack
  );

endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: 1-bit two-flop synchronizer with asynchronous active-low clear.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears both flops
//   d     : asynchronous input
//   q     : synchronized output
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/de2115_return_tx.sv
// de2115_return_tx: serialises one WORD_W word into ceil(WORD_W/CHAN_W) beats on the
// return link, LSB chunk first, each beat shown for CLK_DIV cycles with com_clk low and
// then CLK_DIV cycles with com_clk high. After the last beat com_req drops and the word is
// closed by a four-phase com_ack handshake (ack high, then ack low).
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   data_in        : word to send, sampled only when data_rdy is accepted
//   data_rdy       : one-cycle send request, ignored unless rdy_for_data is high
//   rdy_for_data   : high while idle
//   link (master)  : com_channel, com_clk, com_req out; com_ack in
// Build option: RETURN_TX_PARITY_EN puts even parity of data_in into pad bit WORD_W.
module de2115_return_tx
  import psx_link_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned WORD_W  = psx_link_pkg::WORD_W,
  parameter int unsigned CHAN_W  = psx_link_pkg::CHAN_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WORD_W-1:0]  data_in,
  input  logic               data_rdy,
  output logic               rdy_for_data,
  de2115_return_tx_if.master link
);

  localparam int unsigned Beats = (WORD_W + CHAN_W - 1) / CHAN_W;
  localparam int unsigned PadW  = Beats * CHAN_W;
  localparam int unsigned DivW  = 8;
  localparam int unsigned BeatW = (Beats > 1) ? $clog2(Beats) : 1;
  localparam logic [DivW-1:0]  DivLast  = DivW'(CLK_DIV - 1);
  localparam logic [BeatW-1:0] BeatLast = BeatW'(Beats - 1);

`ifdef RETURN_TX_PARITY_EN
  // The parity bit lives in the pad of the last beat, so there must be a pad.
  if (PadW <= WORD_W) begin : g_parity_no_pad
    $error("RETURN_TX_PARITY_EN needs Beats*CHAN_W > WORD_W");
  end
`endif

  function automatic logic [PadW-1:0] pad_word(input logic [WORD_W-1:0] w);
    logic [PadW-1:0] p;
    p = '0;
    p[WORD_W-1:0] = w;
`ifdef RETURN_TX_PARITY_EN
    p[WORD_W] = ^w;
`endif
    return p;
  endfunction

  link_state_e       state_q;
  logic [DivW-1:0]   div_q;
  logic [BeatW-1:0]  beat_q;
  logic [PadW-1:0]   word_q;   // beats not yet presented, next one in the low bits
  logic [CHAN_W-1:0] chan_q;
  logic              clk_q;
  logic              req_q;
  logic              rdy_q;
  logic              ack_sync;
  logic [PadW-1:0]   padded;

  assign padded = pad_word(data_in);

  sync_2ff u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (link.com_ack),
    .q     (ack_sync)
  );

  // All outputs are registered and updated only at phase boundaries. The channel moves
  // together with the falling strobe, so it is always stable across a rising strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      div_q   <= '0;
      beat_q  <= '0;
      word_q  <= '0;
      chan_q  <= '0;
      clk_q   <= 1'b0;
      req_q   <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          if (data_rdy) begin
            chan_q  <= padded[CHAN_W-1:0];
            word_q  <= padded >> CHAN_W;
            beat_q  <= '0;
            div_q   <= '0;
            req_q   <= 1'b1;
            rdy_q   <= 1'b0;
            state_q <= StLow;
          end
        end
        StLow: begin
          if (div_q == DivLast) begin
            div_q   <= '0;
            clk_q   <= 1'b1;
            state_q <= StHigh;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        StHigh: begin
          if (div_q == DivLast) begin
            div_q <= '0;
            clk_q <= 1'b0;
            if (beat_q == BeatLast) begin
              beat_q  <= '0;
              req_q   <= 1'b0;
              state_q <= StAckHi;
            end else begin
              beat_q  <= beat_q + 1'b1;
              chan_q  <= word_q[CHAN_W-1:0];
              word_q  <= word_q >> CHAN_W;
              state_q <= StLow;
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        StAckHi: begin
          if (ack_sync) begin
            state_q <= StAckLo;
          end
        end
        StAckLo: begin
          if (!ack_sync) begin
            rdy_q   <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign rdy_for_data     = rdy_q;
  assign link.com_channel = chan_q;
  assign link.com_clk     = clk_q;
  assign link.com_req     = req_q;

endmodule
